shield_controller: RTL

- Converts four raw player push-buttons into the 2-bit shield orientation consumed by the shield sprite renderer.
- Per button: synchronises, debounces and edge-detects the input.
- Arbitrates simultaneous presses.
- Commits a new orientation only at a frame boundary, so the shield never tears mid-frame.
- Sits between the board button pins and the shield sprite's rotate input; new_frame_in comes from the video timing generator.

---
 rtl/shield_pkg.sv | 41 ++++
 rtl/button_debouncer.sv | 61 ++++++
 rtl/shield_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/shield_pkg.sv
// Shared shield types: orientation encoding (also used by sprite/collision logic),
// controller FSM states, and the same-cycle press arbitration rule.
package shield_pkg;

    typedef enum logic [1:0] {
        DIR_TOP    = 2'b00,
        DIR_LEFT   = 2'b01,
        DIR_RIGHT  = 2'b10,
        DIR_BOTTOM = 2'b11
    } shield_dir_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COOLDOWN
    } shield_state_t;

    typedef struct packed {
        logic        valid;
        shield_dir_t dir;
    } press_req_t;

    // Priority up > down > left > right; losers are simply dropped.
    function automatic press_req_t arbitrate(input logic up, input logic down,
                                             input logic left, input logic right);
        press_req_t r;
        r.valid = up | down | left | right;
        r.dir   = DIR_TOP;
        if (up) begin
            r.dir = DIR_TOP;
        end else if (down) begin
            r.dir = DIR_BOTTOM;
        end else if (left) begin
            r.dir = DIR_LEFT;
        end else if (right) begin
            r.dir = DIR_RIGHT;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-flop synchroniser, stable-count debouncer and a one-cycle
// press pulse on the debounced rising edge (releases produce nothing).
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 371_250
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_in,
    output logic press_out
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d     = btn_in;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
        // Counter only runs while the synchronised input disagrees; it is
        // capped by the flip, so it never wraps.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press_out = press_q;

endmodule

// File: rtl/shield_controller.sv
// Turns four raw buttons into the registered shield orientation; a new
// orientation is committed only on a frame pulse, followed by a press cooldown.
module shield_controller
    import shield_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 371_250,
    parameter int unsigned COOLDOWN_FRAMES = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn_up_in,
    input  logic       btn_down_in,
    input  logic       btn_left_in,
    input  logic       btn_right_in,
    input  logic       new_frame_in,
    output logic [1:0] rotate_out,
    output logic       moved_out
);

    localparam int unsigned CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

    logic press_up, press_down, press_left, press_right;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .btn_in   (btn_up_in),
        .press_out(press_up)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .btn_in   (btn_down_in),
        .press_out(press_down)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_left (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .btn_in   (btn_left_in),
        .press_out(press_left)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_right (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .btn_in   (btn_right_in),
        .press_out(press_right)
    );

    shield_state_t   state_q, state_d;
    shield_dir_t     rot_q, rot_d;
    shield_dir_t     pend_q, pend_d;
    shield_dir_t     commit_dir;
    logic            moved_q, moved_d;
    logic [CD_W-1:0] cd_q, cd_d;
    press_req_t      req;

    always_comb begin
        req        = arbitrate(press_up, press_down, press_left, press_right);
        state_d    = state_q;
        rot_d      = rot_q;
        pend_d     = pend_q;
        cd_d       = cd_q;
        moved_d    = 1'b0;
        commit_dir = pend_q;
        case (state_q)
            IDLE: begin
                if (req.valid && (req.dir != rot_q)) begin
                    state_d = PENDING;
                    pend_d  = req.dir;
                end
            end
            PENDING: begin
                // Latest press wins, including one landing on the frame pulse itself.
                if (req.valid) begin
                    commit_dir = req.dir;
                end
                pend_d = commit_dir;
                if (new_frame_in) begin
                    rot_d   = commit_dir;
                    moved_d = (commit_dir != rot_q);
                    cd_d    = CD_LOAD;
                    state_d = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (new_frame_in) begin
                    cd_d = cd_q - CD_ONE;
                    if (cd_q <= CD_ONE) begin
                        cd_d    = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            rot_q   <= DIR_TOP;
            pend_q  <= DIR_TOP;
            cd_q    <= '0;
            moved_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            pend_q  <= pend_d;
            cd_q    <= cd_d;
            moved_q <= moved_d;
        end
    end

    assign rotate_out = rot_q;
    assign moved_out  = moved_q;

endmodule
